// File: rtl/tft_frame_sequencer.sv
// TFT panel sequencer: hardware reset, SLPOUT/DISPON power-up, then a per-frame
// CASET/RASET/RAMWR header followed by a pixel stream forwarded to the SPI word shifter.
module tft_frame_sequencer #(
    parameter int H_RES      = 128,
    parameter int V_RES      = 160,
    parameter int X_OFS      = 0,
    parameter int Y_OFS      = 0,
    parameter int RST_CYCLES = 62500,
    parameter int INIT_WAIT  = 750000,
    parameter int SLP_CYCLES = 750000,
    parameter int GAP_CYCLES = 16
) (
    input  logic        MasterCLK,
    input  logic        Reset,
    input  logic        frame_en,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [15:0] tx_data,
    output logic        tx_len,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        tx_idle,
    output logic        lcd_rs,
    output logic        lcd_cs_n,
    output logic        lcd_rst_n,
    output logic        init_done,
    output logic        frame_start
);

    typedef enum logic [3:0] {
        S_RST_LOW, S_RST_WAIT, S_SLPOUT, S_SLP_WAIT, S_DISPON, S_IDLE, S_CASET,
        S_CASET_ARG, S_RASET, S_RASET_ARG, S_RAMWR, S_PIXELS, S_DRAIN, S_GAP
    } state_t;

    localparam logic [15:0] XS       = 16'(X_OFS);
    localparam logic [15:0] XE       = 16'(X_OFS + H_RES - 1);
    localparam logic [15:0] YS       = 16'(Y_OFS);
    localparam logic [15:0] YE       = 16'(Y_OFS + V_RES - 1);
    localparam logic [15:0] PIX_LAST = 16'(H_RES * V_RES - 1);
    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] INI_LAST = 32'(INIT_WAIT - 1);
    localparam logic [31:0] SLP_LAST = 32'(SLP_CYCLES - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

    state_t      r_state, w_next_state;
    logic [31:0] r_cnt, w_cnt_next;
    logic [1:0]  r_byte, w_byte_next;
    logic [15:0] r_pix, w_pix_next;
    logic        r_cmd_busy, r_init_done, r_frame_start;
    logic [15:0] w_tx_data;
    logic        w_tx_len, w_tx_valid, w_rs, w_cs_n, w_rst_n, w_pix_ready;

    function automatic logic [15:0] arg_byte(input logic [15:0] start_v,
                                             input logic [15:0] end_v,
                                             input logic [1:0]  idx);
        case (idx)
            2'd0:    arg_byte = {8'h00, start_v[15:8]};
            2'd1:    arg_byte = {8'h00, start_v[7:0]};
            2'd2:    arg_byte = {8'h00, end_v[15:8]};
            default: arg_byte = {8'h00, end_v[7:0]};
        endcase
    endfunction

    // Next-state, counters and shifter/panel outputs decoded from the current state.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_byte_next  = r_byte;
        w_pix_next   = r_pix;
        w_tx_data    = 16'h0000;
        w_tx_len     = 1'b0;
        w_tx_valid   = 1'b0;
        w_rs         = 1'b0;
        w_cs_n       = ~r_cmd_busy;
        w_rst_n      = 1'b1;
        w_pix_ready  = 1'b0;
        case (r_state)
            S_RST_LOW: begin
                w_rst_n = 1'b0;
                if (r_cnt == RST_LAST) begin
                    w_cnt_next   = 32'd0;
                    w_next_state = S_RST_WAIT;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            S_RST_WAIT: begin
                if (r_cnt == INI_LAST) begin
                    w_cnt_next   = 32'd0;
                    w_next_state = S_SLPOUT;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            S_SLPOUT: begin
                w_tx_valid = 1'b1;
                w_tx_data  = 16'h0011;
                w_cs_n     = 1'b0;
                if (tx_ready) w_next_state = S_SLP_WAIT;
                else          w_next_state = S_SLPOUT;
            end
            // The sleep-out delay only starts once the shifter has finished the command.
            S_SLP_WAIT: begin
                if (r_cmd_busy) begin
                    w_cnt_next = r_cnt;
                end else if (r_cnt == SLP_LAST) begin
                    w_cnt_next   = 32'd0;
                    w_next_state = S_DISPON;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            S_DISPON: begin
                w_tx_valid = 1'b1;
                w_tx_data  = 16'h0029;
                w_cs_n     = 1'b0;
                if (tx_ready) w_next_state = S_IDLE;
                else          w_next_state = S_DISPON;
            end
            S_IDLE: begin
                if (frame_en) w_next_state = S_CASET;
                else          w_next_state = S_IDLE;
            end
            S_CASET, S_RASET, S_RAMWR: begin
                w_tx_valid = 1'b1;
                w_cs_n     = 1'b0;
                if (r_state == S_CASET)      w_tx_data = 16'h002A;
                else if (r_state == S_RASET) w_tx_data = 16'h002B;
                else                         w_tx_data = 16'h002C;
                if (!tx_ready)               w_next_state = r_state;
                else if (r_state == S_CASET) w_next_state = S_CASET_ARG;
                else if (r_state == S_RASET) w_next_state = S_RASET_ARG;
                else                         w_next_state = S_PIXELS;
            end
            S_CASET_ARG, S_RASET_ARG: begin
                w_tx_valid = 1'b1;
                w_rs       = 1'b1;
                w_cs_n     = 1'b0;
                if (r_state == S_CASET_ARG) w_tx_data = arg_byte(XS, XE, r_byte);
                else                        w_tx_data = arg_byte(YS, YE, r_byte);
                if (tx_ready && r_byte == 2'd3) begin
                    w_byte_next  = 2'd0;
                    w_next_state = (r_state == S_CASET_ARG) ? S_RASET : S_RAMWR;
                end else if (tx_ready) begin
                    w_byte_next = r_byte + 2'd1;
                end else begin
                    w_byte_next = r_byte;
                end
            end
            S_PIXELS: begin
                w_tx_valid  = pix_valid;
                w_tx_data   = pix_data;
                w_tx_len    = 1'b1;
                w_rs        = 1'b1;
                w_cs_n      = 1'b0;
                w_pix_ready = tx_ready;
                if (pix_valid && tx_ready && r_pix == PIX_LAST) begin
                    w_pix_next   = 16'd0;
                    w_next_state = S_DRAIN;
                end else if (pix_valid && tx_ready) begin
                    w_pix_next = r_pix + 16'd1;
                end else begin
                    w_pix_next = r_pix;
                end
            end
            S_DRAIN: begin
                w_cs_n = 1'b0;
                if (tx_idle) w_next_state = S_GAP;
                else         w_next_state = S_DRAIN;
            end
            // frame_en is sampled only here, at the frame boundary, so back-to-back
            // frames see CS high for exactly the gap length.
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_next   = 32'd0;
                    w_next_state = frame_en ? S_CASET : S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            default: begin
                w_next_state = S_RST_LOW;
                w_cnt_next   = 32'd0;
            end
        endcase
    end

    // State, counters and status flags; Reset restarts the full power-up sequence.
    always_ff @(posedge MasterCLK or posedge Reset) begin
        if (Reset) begin
            r_state       <= S_RST_LOW;
            r_cnt         <= 32'd0;
            r_byte        <= 2'd0;
            r_pix         <= 16'd0;
            r_cmd_busy    <= 1'b0;
            r_init_done   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_cnt         <= w_cnt_next;
            r_byte        <= w_byte_next;
            r_pix         <= w_pix_next;
            r_frame_start <= (r_state == S_CASET) && tx_ready;
            if ((r_state == S_SLPOUT || r_state == S_DISPON) && tx_ready) r_cmd_busy <= 1'b1;
            else if (tx_idle)                                             r_cmd_busy <= 1'b0;
            else                                                          r_cmd_busy <= r_cmd_busy;
            if (r_state == S_DISPON && tx_ready) r_init_done <= 1'b1;
            else                                 r_init_done <= r_init_done;
        end
    end

    assign tx_data     = w_tx_data;
    assign tx_len      = w_tx_len;
    assign tx_valid    = w_tx_valid;
    assign lcd_rs      = w_rs;
    assign lcd_cs_n    = w_cs_n;
    assign lcd_rst_n   = w_rst_n;
    assign pix_ready   = w_pix_ready;
    assign init_done   = r_init_done;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_tft_frame_sequencer.sv
// Directed bench for tft_frame_sequencer with a small panel and short delays so the
// power-up sequence, frame headers, stalls, frame_en drop and mid-frame reset all fit.
module tb_tft_frame_sequencer;

    localparam int H = 4, V = 2, XO = 2, YO = 1;
    localparam int RSTC = 5, INITW = 7, SLPC = 6, GAPC = 3;

    logic        clk = 1'b0;
    logic        Reset, frame_en, pix_valid, pix_ready, tx_len, tx_valid, tx_ready, tx_idle;
    logic        lcd_rs, lcd_cs_n, lcd_rst_n, init_done, frame_start;
    logic [15:0] pix_data, tx_data;

    int          n_vec = 0, n_err = 0;
    logic [17:0] log_q[$];
    int          src_idx = 0, frame_base = 0, drop_at = -1, fs_cnt = 0, sh = 0, cs_pre = 0;
    bit          rnd = 1'b0;
    logic        s_valid, s_cs_n, s_rst_n, s_rs, s_len, s_init;
    logic [15:0] s_data;

    always #5 clk = ~clk;

    tft_frame_sequencer #(
        .H_RES(H), .V_RES(V), .X_OFS(XO), .Y_OFS(YO),
        .RST_CYCLES(RSTC), .INIT_WAIT(INITW), .SLP_CYCLES(SLPC), .GAP_CYCLES(GAPC)
    ) dut (
        .MasterCLK(clk), .Reset(Reset), .frame_en(frame_en), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .tx_data(tx_data), .tx_len(tx_len),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_idle(tx_idle), .lcd_rs(lcd_rs),
        .lcd_cs_n(lcd_cs_n), .lcd_rst_n(lcd_rst_n), .init_done(init_done),
        .frame_start(frame_start)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample at negedge, then drive inputs and the shifter model just after posedge.
    task automatic cycle();
        bit hs;
        @(negedge clk);
        hs = tx_valid && tx_ready;
        if (hs) log_q.push_back({lcd_rs, tx_len, tx_data});
        if (pix_valid && pix_ready) src_idx++;
        if (frame_start) fs_cnt++;
        s_valid = tx_valid; s_cs_n = lcd_cs_n; s_rst_n = lcd_rst_n;
        s_rs = lcd_rs; s_len = tx_len; s_data = tx_data; s_init = init_done;
        @(posedge clk);
        #1;
        if (hs) sh = 3;
        else if (sh != 0) sh--;
        tx_idle = (sh == 0);
        if (drop_at >= 0 && (src_idx - frame_base) == drop_at) frame_en = 1'b0;
        tx_ready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        pix_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        pix_data  = 16'hA000 + 16'(src_idx);
    endtask

    task automatic powerup();
        int n, g;
        n = 0; g = 0;
        cycle();
        while (!s_rst_n && g < 5000) begin n++; g++; cycle(); end
        check_val("rst_low_cycles", n, RSTC);
        n = 0;
        while (!s_valid && g < 5000) begin n++; g++; cycle(); end
        check_val("init_wait_cycles", n, INITW);
        check_val("slpout_word", {s_rs, s_len, s_data}, 18'h00011);
        check_val("slpout_cs", s_cs_n, 1'b0);
        check_val("init_done_early", s_init, 1'b0);
        n = 0;
        cycle();
        while (!s_valid && g < 5000) begin if (s_cs_n) n++; g++; cycle(); end
        check_val("slp_cs_high_cycles", n, SLPC);
        check_val("dispon_word", {s_rs, s_len, s_data}, 18'h00029);
        cycle();
        check_val("init_done", s_init, 1'b1);
    endtask

    task automatic run_words(input int n);
        int g;
        g = 0; cs_pre = 0;
        while (log_q.size() < n && g < 5000) begin
            cycle();
            if (log_q.size() == 0 && s_cs_n) cs_pre++;
            g++;
        end
    endtask

    task automatic check_frame(input int base);
        logic [17:0] exp_w [0:18];
        exp_w[0] = 18'h0002A; exp_w[1] = 18'h20000; exp_w[2]  = 18'h20002;
        exp_w[3] = 18'h20000; exp_w[4] = 18'h20005; exp_w[5]  = 18'h0002B;
        exp_w[6] = 18'h20000; exp_w[7] = 18'h20001; exp_w[8]  = 18'h20000;
        exp_w[9] = 18'h20002; exp_w[10] = 18'h0002C;
        for (int k = 0; k < 8; k++) exp_w[11 + k] = {2'b11, 16'hA000 + 16'(base + k)};
        check_val("frame_words", log_q.size(), 19);
        for (int i = 0; i < 19; i++)
            if (i < log_q.size()) check_val($sformatf("word%0d", i), log_q[i], exp_w[i]);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_rst_n"}, lcd_rst_n, 1'b0);
        check_val({pfx, "_cs_n"}, lcd_cs_n, 1'b1);
        check_val({pfx, "_tx_valid"}, tx_valid, 1'b0);
        check_val({pfx, "_pix_ready"}, pix_ready, 1'b0);
        check_val({pfx, "_init_done"}, init_done, 1'b0);
        check_val({pfx, "_frame_start"}, frame_start, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        Reset = 1'b1; frame_en = 1'b0; pix_valid = 1'b1; pix_data = 16'hA000;
        tx_ready = 1'b1; tx_idle = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        Reset = 1'b0;
        powerup();
        log_q.delete();

        repeat (10) cycle();
        check_val("idle_no_tx", log_q.size(), 0);
        check_val("idle_cs", s_cs_n, 1'b1);

        // Frame 1: no stalls.
        frame_en = 1'b1; frame_base = src_idx; fs_cnt = 0;
        run_words(19);
        check_frame(frame_base);
        check_val("frame_start_1", fs_cnt, 1);

        // Frame 2: back-to-back with random tx_ready / pix_valid stalls.
        log_q.delete(); frame_base = src_idx; fs_cnt = 0; rnd = 1'b1;
        run_words(19);
        check_val("gap_cs_1", cs_pre, GAPC);
        check_frame(frame_base);
        check_val("frame_start_2", fs_cnt, 1);
        check_val("pix_consumed_2", src_idx - frame_base, 8);

        // Frame 3: frame_en dropped while pixel 3 is offered.
        rnd = 1'b0; log_q.delete(); frame_base = src_idx; fs_cnt = 0; drop_at = 2;
        run_words(19);
        check_val("gap_cs_2", cs_pre, GAPC);
        check_frame(frame_base);
        drop_at = -1;
        repeat (40) cycle();
        check_val("no_new_caset", log_q.size(), 19);
        check_val("cs_high_after_drop", s_cs_n, 1'b1);

        // Frame 4: reset asserted while pixel 5 is offered.
        frame_en = 1'b1; log_q.delete(); frame_base = src_idx;
        g = 0;
        while ((src_idx - frame_base) < 4 && g < 5000) begin cycle(); g++; end
        check_val("pix5_offered", tx_valid, 1'b1);
        Reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        sh = 0; tx_idle = 1'b1; frame_en = 1'b0;
        @(posedge clk); #1;
        Reset = 1'b0;
        powerup();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
